// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one synchronous write port,
// and a per-register pending scoreboard for RAW hazard detection against writebacks.
module reg_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_pend_a,
    output logic              rd_pend_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              all_idle
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic              wr_ok;

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(gi);
            localparam bit HARD_ZERO = (ZERO_REG != 0) && (gi == 0);
            logic [DATA_W-1:0] val_q;
            logic              set_w;
            logic              clr_w;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    val_q <= RST_VAL;
                end else if (wr_ok && (wr_addr == ADDR_W'(gi))) begin
                    val_q <= wr_data;
                end
            end
            assign rf_q[gi] = val_q;

            // A same-cycle issue wins over the clear: the write belongs to the older instruction.
            assign set_w      = iss_en && (iss_addr == ADDR_W'(gi)) && !HARD_ZERO;
            assign clr_w      = wr_en && (wr_addr == ADDR_W'(gi));
            assign pend_d[gi] = set_w | (pend_q[gi] & ~clr_w);
        end
    endgenerate

    always_comb begin
        cnt_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;
    assign all_idle = (cnt_q == '0);

    logic [ADDR_W-1:0] port_addr [2];
    logic [DATA_W-1:0] port_data [2];
    logic [1:0]        port_pend;

    assign port_addr[0] = rd_addr_a;
    assign port_addr[1] = rd_addr_b;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                port_data[gi] = rf_q[port_addr[gi]];
                port_pend[gi] = pend_q[port_addr[gi]];
                if ((BYPASS != 0) && wr_en && (wr_addr == port_addr[gi])) begin
                    port_data[gi] = wr_data;
                    port_pend[gi] = 1'b0;
                end
                if ((ZERO_REG != 0) && (port_addr[gi] == '0)) begin
                    port_data[gi] = '0;
                    port_pend[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign rd_data_a = port_data[0];
    assign rd_data_b = port_data[1];
    assign rd_pend_a = port_pend[0];
    assign rd_pend_b = port_pend[1];
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: two instances (bypass/no-zero and no-bypass/zero-reg) share stimulus;
// expectations are queued per cycle and a negedge monitor pops and compares them.
module tb_reg_file_sb;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr, iss_addr;
    logic [7:0] wr_data;
    logic       wr_en, iss_en;

    logic [7:0] rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1;
    logic       rd_pend_a0, rd_pend_b0, rd_pend_a1, rd_pend_b1;
    logic [3:0] pend_cnt0, pend_cnt1;
    logic       all_idle0, all_idle1;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0),
        .rd_pend_a(rd_pend_a0), .rd_pend_b(rd_pend_b0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .pend_cnt(pend_cnt0), .all_idle(all_idle0)
    );

    reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a1), .rd_data_b(rd_data_b1),
        .rd_pend_a(rd_pend_a1), .rd_pend_b(rd_pend_b1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .pend_cnt(pend_cnt1), .all_idle(all_idle1)
    );

    // Output selectors
    localparam int DA = 0, DB = 1, PA = 2, PB = 3, CNT = 4, IDLE = 5;

    typedef struct {
        int         cyc;
        int         dut;
        int         sel;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] observe(int dut, int sel);
        logic [7:0] r;
        r = 8'h00;
        case (sel)
            DA:   r = (dut == 0) ? rd_data_a0 : rd_data_a1;
            DB:   r = (dut == 0) ? rd_data_b0 : rd_data_b1;
            PA:   r = {7'd0, (dut == 0) ? rd_pend_a0 : rd_pend_a1};
            PB:   r = {7'd0, (dut == 0) ? rd_pend_b0 : rd_pend_b1};
            CNT:  r = {4'd0, (dut == 0) ? pend_cnt0 : pend_cnt1};
            default: r = {7'd0, (dut == 0) ? all_idle0 : all_idle1};
        endcase
        return r;
    endfunction

    // Monitor: compares every expectation stamped for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [7:0] got;
            e = q.pop_front();
            got = observe(e.dut, e.sel);
            n_vec++;
            if (e.cyc < cyc) begin
                n_err++;
                $display("FAIL %s dut%0d: stale expectation from cycle %0d at cycle %0d", e.name, e.dut, e.cyc, cyc);
            end else if (got !== e.val) begin
                n_err++;
                $display("FAIL %s dut%0d: got %02h, expected %02h", e.name, e.dut, got, e.val);
            end else begin
                $display("ok   %s dut%0d: %02h", e.name, e.dut, got);
            end
        end
    end

    task automatic step(input logic r, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic ie, input logic [2:0] ia, input logic [2:0] ra, input logic [2:0] rb);
        @(posedge clk);
        #1;
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; rd_addr_a = ra; rd_addr_b = rb;
    endtask

    task automatic expect_one(input int dut, input int sel, input logic [7:0] val, input string name);
        exp_t e;
        e.cyc = cyc; e.dut = dut; e.sel = sel; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic expect_both(input int sel, input logic [7:0] val, input string name);
        expect_one(0, sel, val, name);
        expect_one(1, sel, val, name);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; rd_addr_a = '0; rd_addr_b = '0;

        // 1: reset values
        step(1, 0, 0, 8'h00, 0, 0, 5, 7);
        expect_both(DA, 8'h05, "rst_r5");
        expect_both(DB, 8'h07, "rst_r7");
        expect_both(CNT, 8'd0, "rst_cnt");
        expect_both(IDLE, 8'd1, "rst_idle");
        expect_both(PA, 8'd0, "rst_pend");
        // 2: write r3 with bypass vs. without
        step(1, 1, 3, 8'hA5, 0, 0, 3, 3);
        expect_one(0, DA, 8'hA5, "wr_byp_a");
        expect_one(0, DB, 8'hA5, "wr_byp_b");
        expect_one(1, DA, 8'h03, "wr_nobyp_a");
        expect_one(1, DB, 8'h03, "wr_nobyp_b");
        // 3: write visible, issue r2
        step(1, 0, 0, 8'h00, 1, 2, 3, 2);
        expect_both(DA, 8'hA5, "wr_late");
        expect_both(PB, 8'd0, "iss2_not_yet");
        // 4: issue r6
        step(1, 0, 0, 8'h00, 1, 6, 2, 6);
        expect_both(PA, 8'd1, "pend2");
        expect_both(PB, 8'd0, "pend6_not_yet");
        expect_both(CNT, 8'd1, "cnt1");
        expect_both(IDLE, 8'd0, "busy");
        // 5: writeback r2
        step(1, 1, 2, 8'h22, 0, 0, 2, 6);
        expect_one(0, PA, 8'd0, "wb2_pend_byp");
        expect_one(0, DA, 8'h22, "wb2_data_byp");
        expect_one(1, PA, 8'd1, "wb2_pend_nobyp");
        expect_one(1, DA, 8'h02, "wb2_data_nobyp");
        expect_both(PB, 8'd1, "pend6");
        expect_both(CNT, 8'd2, "cnt2");
        // 6: issue r4
        step(1, 0, 0, 8'h00, 1, 4, 2, 2);
        expect_both(PA, 8'd0, "pend2_clr");
        expect_both(DB, 8'h22, "r2_data");
        expect_both(CNT, 8'd1, "cnt_after_wb");
        // 7: collision issue+write on r4
        step(1, 1, 4, 8'h3C, 1, 4, 4, 4);
        expect_one(0, DA, 8'h3C, "coll_data_byp");
        expect_one(0, PA, 8'd0, "coll_pend_byp");
        expect_one(1, DA, 8'h04, "coll_data_nobyp");
        expect_one(1, PA, 8'd1, "coll_pend_nobyp");
        expect_both(CNT, 8'd2, "coll_cnt_pre");
        // 8: issue r1 while writing r4
        step(1, 1, 4, 8'h5A, 1, 1, 4, 1);
        expect_one(0, DA, 8'h5A, "swap_data_byp");
        expect_one(1, DA, 8'h3C, "coll_result");
        expect_one(1, PA, 8'd1, "coll_pend_kept");
        expect_both(PB, 8'd0, "pend1_not_yet");
        expect_both(CNT, 8'd2, "coll_cnt");
        // 9: idle
        step(1, 0, 0, 8'h00, 0, 0, 4, 1);
        expect_both(DA, 8'h5A, "r4_data");
        expect_both(PA, 8'd0, "pend4_clr");
        expect_both(PB, 8'd1, "pend1_set");
        expect_both(DB, 8'h01, "r1_data");
        expect_both(CNT, 8'd2, "swap_cnt");
        // 10: write + issue to index 0
        step(1, 1, 0, 8'hFF, 1, 0, 0, 0);
        expect_one(0, DA, 8'hFF, "r0_byp");
        expect_one(0, PA, 8'd0, "r0_pend_byp");
        expect_one(1, DA, 8'h00, "zero_data");
        expect_one(1, PB, 8'd0, "zero_pend");
        expect_both(CNT, 8'd2, "zero_cnt_pre");
        // 11: write r1=99 with collision issue
        step(1, 1, 1, 8'h99, 1, 1, 0, 1);
        expect_one(0, DA, 8'hFF, "r0_written");
        expect_one(0, PA, 8'd1, "r0_pending");
        expect_one(0, CNT, 8'd3, "cnt3");
        expect_one(0, DB, 8'h99, "r1_byp");
        expect_one(1, DA, 8'h00, "zero_data_kept");
        expect_one(1, PA, 8'd0, "zero_pend_kept");
        expect_one(1, CNT, 8'd2, "zero_cnt");
        expect_one(1, DB, 8'h01, "r1_nobyp");
        // 12: state before reset
        step(1, 0, 0, 8'h00, 0, 0, 1, 6);
        expect_both(DA, 8'h99, "r1_99");
        expect_both(PA, 8'd1, "pend1_kept");
        expect_both(PB, 8'd1, "pend6_kept");
        expect_one(0, CNT, 8'd3, "cnt3_hold");
        // 13: reset with write and issue active (no check this cycle)
        step(0, 1, 1, 8'h77, 1, 3, 1, 3);
        // 14: reset discarded everything
        step(1, 0, 0, 8'h00, 0, 0, 1, 3);
        expect_both(DA, 8'h01, "mid_rst_r1");
        expect_both(DB, 8'h03, "mid_rst_r3");
        expect_both(PB, 8'd0, "mid_rst_pend3");
        expect_both(CNT, 8'd0, "mid_rst_cnt");
        expect_both(IDLE, 8'd1, "mid_rst_idle");
        // 15: other registers restored
        step(1, 0, 0, 8'h00, 0, 0, 4, 0);
        expect_both(DA, 8'h04, "mid_rst_r4");
        expect_both(DB, 8'h00, "mid_rst_r0");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
